// File: rtl/serial_pattern_driver.sv
// Parallel-to-serial pattern driver: shifts len bits of data out on sout, MSB first,
// holding each bit BIT_TICKS clocks, with ready/load handshake, abort and done pulse.
module serial_pattern_driver #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LEN_W     = 5,
    parameter int unsigned BIT_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             bit_strobe,
    output logic             done
);

    localparam int unsigned       TICK_W    = $clog2(BIT_TICKS) + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(WIDTH);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shreg, shreg_nxt;
    logic [LEN_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [LEN_W-1:0]  len_eff;
    logic [TICK_W-1:0] tick_cnt, tick_nxt;
    logic              done_nxt;
    logic              ready_nxt, sout_nxt, valid_nxt, strobe_nxt;

    assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tick_cnt   <= '0;
            ready      <= 1'b1;
            sout       <= 1'b0;
            bit_valid  <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            tick_cnt   <= tick_nxt;
            ready      <= ready_nxt;
            sout       <= sout_nxt;
            bit_valid  <= valid_nxt;
            bit_strobe <= strobe_nxt;
            done       <= done_nxt;
        end
    end

    // Next state; the pattern is left-aligned on capture so the current bit is always the MSB
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        tick_nxt    = tick_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (load && (len != '0)) begin
                    state_nxt   = SHIFT;
                    shreg_nxt   = data << (LEN_MAX - len_eff);
                    bit_cnt_nxt = len_eff - LEN_W'(1);
                    tick_nxt    = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    shreg_nxt   = '0;
                    bit_cnt_nxt = '0;
                    tick_nxt    = '0;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_nxt = '0;
                    if (bit_cnt == '0) begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt - LEN_W'(1);
                        shreg_nxt   = shreg << 1;
                    end
                end else begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        ready_nxt  = 1'b1;
        valid_nxt  = 1'b0;
        sout_nxt   = 1'b0;
        strobe_nxt = 1'b0;
        if (state_nxt == SHIFT) begin
            ready_nxt  = 1'b0;
            valid_nxt  = 1'b1;
            sout_nxt   = shreg_nxt[WIDTH-1];
            strobe_nxt = (tick_nxt == '0);
        end
    end

endmodule

// File: tb/tb_serial_pattern_driver.sv
// Bench for serial_pattern_driver: two instances (1 and 3 clocks per bit) checked every
// cycle against a timeline model of the serial stream.
module tb_serial_pattern_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        abort;
    logic [15:0] data;
    logic [4:0]  len;
    logic [1:0]  ready_w, sout_w, valid_w, strobe_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_pattern_driver #(.WIDTH(16), .LEN_W(5), .BIT_TICKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load), .data(data), .len(len), .abort(abort),
        .ready(ready_w[0]), .sout(sout_w[0]), .bit_valid(valid_w[0]),
        .bit_strobe(strobe_w[0]), .done(done_w[0])
    );

    serial_pattern_driver #(.WIDTH(16), .LEN_W(5), .BIT_TICKS(3)) u_dut3 (
        .clk(clk), .rst(rst), .load(load), .data(data), .len(len), .abort(abort),
        .ready(ready_w[1]), .sout(sout_w[1]), .bit_valid(valid_w[1]),
        .bit_strobe(strobe_w[1]), .done(done_w[1])
    );

    // Model: a pattern occupies cycles 1..len*bt after its load; done follows the last one
    int          bt [2] = '{1, 3};
    bit          m_active [2];
    int          m_j [2];
    logic [15:0] m_data [2];
    int          m_len [2];
    bit          m_done [2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_active[i] <= 1'b0;
                m_done[i]   <= 1'b0;
                m_j[i]      <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_active[i]) begin
                    if (abort) begin
                        m_active[i] <= 1'b0;
                    end else if (m_j[i] == m_len[i] * bt[i]) begin
                        m_active[i] <= 1'b0;
                        m_done[i]   <= 1'b1;
                    end else begin
                        m_j[i] <= m_j[i] + 1;
                    end
                end else if (load && len != 5'd0) begin
                    m_active[i] <= 1'b1;
                    m_j[i]      <= 1;
                    m_data[i]   <= data;
                    m_len[i]    <= (len > 5'd16) ? 16 : int'(len);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic es;
            logic ek;
            int   idx;
            es = 1'b0;
            ek = 1'b0;
            if (m_active[i]) begin
                idx = m_len[i] - 1 - (m_j[i] - 1) / bt[i];
                es  = m_data[i][idx];
                ek  = ((m_j[i] - 1) % bt[i]) == 0;
            end
            check($sformatf("ready_bt%0d", bt[i]),  32'(ready_w[i]),  32'(!m_active[i]));
            check($sformatf("valid_bt%0d", bt[i]),  32'(valid_w[i]),  32'(m_active[i]));
            check($sformatf("sout_bt%0d", bt[i]),   32'(sout_w[i]),   32'(es));
            check($sformatf("strobe_bt%0d", bt[i]), 32'(strobe_w[i]), 32'(ek));
            check($sformatf("done_bt%0d", bt[i]),   32'(done_w[i]),   32'(m_done[i]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        compare_all();
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_pat(input logic [15:0] d, input logic [4:0] l);
        load = 1'b1;
        data = d;
        len  = l;
        @(negedge clk);
        load = 1'b0;
        data = 16'($urandom);
    endtask

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        abort = 1'b0;
        data  = '0;
        len   = '0;
        tick(3);
        rst = 1'b1;
        tick(2);

        load_pat(16'h000D, 5'd4);
        tick(8);
        load_pat(16'h011D, 5'd9);
        tick(32);

        // Load while busy must not disturb the running pattern
        load_pat(16'h000D, 5'd4);
        tick(1);
        load_pat(16'hFFFF, 5'd16);
        tick(16);

        load_pat(16'hFFFF, 5'd0);
        tick(3);
        load_pat(16'h8001, 5'd20);
        tick(52);

        // Abort on the second bit, then reload straight away
        load_pat(16'h000D, 5'd4);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        load_pat(16'h000B, 5'd4);
        tick(16);

        // Held load: every done cycle doubles as the next accept
        load = 1'b1;
        data = 16'h000D;
        len  = 5'd4;
        tick(30);
        load = 1'b0;
        tick(16);

        // Asynchronous reset between edges, mid-pattern
        load_pat(16'h011D, 5'd9);
        tick(5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        compare_all();
        tick(2);
        rst = 1'b1;
        tick(15);

        for (int c = 0; c < 3000; c++) begin
            load  = ($urandom % 6) == 0;
            abort = ($urandom % 25) == 0;
            data  = 16'($urandom);
            len   = 5'($urandom_range(0, 20));
            @(negedge clk);
        end
        load  = 1'b0;
        abort = 1'b0;
        tick(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
